register_file: RTL and testbench
================================

Name: register_file

Overview:
- Parametrised successor to the single-cycle MIPS general-purpose register file.
- Storage is NUM_REGS x DATA_WIDTH, with two combinational read ports and one synchronous write port.
- Register 0 is hardwired to zero.
- Adds a per-register busy scoreboard so the control path can stall on pending multicycle producers (multiply/divide, load miss).
- Sits between the decode stage (read/mark) and the writeback stage (write/clear).

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 5, width of the register index.
- NUM_REGS, 32, number of registers; must be <= 2**ADDR_WIDTH and >= 2.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state.
- reg_write  input  1  write enable for the writeback port.
- write_register  input  ADDR_WIDTH  writeback destination index.
- write_data  input  DATA_WIDTH  writeback data.
- read_register_1  input  ADDR_WIDTH  read port 1 index.
- read_register_2  input  ADDR_WIDTH  read port 2 index.
- read_data_1  output  DATA_WIDTH  read port 1 data, combinational.
- read_data_2  output  DATA_WIDTH  read port 2 data, combinational.
- mark_busy  input  1  issue of a multicycle producer; sets a busy bit.
- mark_register  input  ADDR_WIDTH  destination index to mark busy.
- busy_1  output  1  busy bit for read_register_1, combinational.
- busy_2  output  1  busy bit for read_register_2, combinational.
- busy_count  output  ADDR_WIDTH+1  number of registers currently busy.

Behaviour:
- Reset (asynchronous, active-high):
  - All registers become 0, all busy bits 0, busy_count 0.
  - read_data_1/2 and busy_1/2 therefore read 0 while reset is held.
  - Reset asserted mid-operation discards any in-flight write or mark for that edge.
- Write:
  - At the rising clock edge, if reg_write and write_register != 0 and write_register < NUM_REGS, then regs[write_register] <= write_data.
  - A write to index 0 or to an out-of-range index is ignored.
- Read:
  - Purely combinational, zero latency.
  - Index 0 returns 0.
  - An out-of-range index returns 0, and its busy output is 0.
  - Both ports may address the same register; each returns identical data.
- Scoreboard, per register, evaluated at the rising edge:
  - mark_busy && mark_register == r (r != 0) sets busy[r].
  - reg_write && write_register == r clears busy[r].
  - If both hit the same r in the same cycle, set wins: a new producer has issued.
  - Marking an already-busy register keeps it busy; no error or count change.
  - Writing a non-busy register is legal; busy stays 0.
  - Index 0 is never busy.
- busy_count:
  - Registered population count of the busy bits, updated in the same edge as the bits.
  - Range 0..NUM_REGS-1.
  - Delta per cycle is -1, 0 or +1; a set and a clear to different registers in the same cycle leave the count unchanged.
- No internal state machine beyond the storage and busy arrays; all sequential elements use the asynchronous reset.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Same-cycle write-to-read forwarding. If reg_write && write_register != 0 && write_register == read_register_n, then read_data_n = write_data and busy_n = 0 in that same cycle, even if a mark_busy to that register is also pending.
  - This gives zero-cycle writeback-to-decode.
- Undefined:
  - Reads return the stored array value only, so new data is visible from the cycle after the write edge.
  - busy_n reflects the stored bit only.
- The scoreboard update rules are identical in both builds.

Test Plan:
- Reset, then read all indices 0..31 -> every read_data is 0, every busy is 0, busy_count 0.
- Write 0xDEADBEEF to r5, read r5 on port 1 and port 2 next cycle -> both 0xDEADBEEF; write 0x12345678 to r0 -> r0 still reads 0.
- mark_busy r7, then r9 on consecutive cycles -> busy_count 1 then 2, busy_1=1 with read_register_1=7; write r7=0x55 -> busy_count 1, busy for r7 is 0, read r7 = 0x55.
- Same cycle: mark_busy r3 and reg_write r3=0xAA -> next cycle busy for r3 is 1, r3 reads 0xAA, busy_count +1.
- With REGFILE_BYPASS_EN: reg_write r10=0xCAFE while read_register_1=10 -> read_data_1=0xCAFE in the same cycle. Without the macro -> old value that cycle, 0xCAFE next cycle.
- Assert reset asynchronously mid-cycle after r4=0x99 and r4 marked busy -> read r4 = 0 and busy_count = 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/register_file_if.sv
// Bus bundle between decode/writeback and the register file.
// Carries the read, write and scoreboard-mark signals.
interface register_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  reg_write;
  logic [ADDR_WIDTH-1:0] write_register;
  logic [DATA_WIDTH-1:0] write_data;
  logic [ADDR_WIDTH-1:0] read_register_1;
  logic [ADDR_WIDTH-1:0] read_register_2;
  logic [DATA_WIDTH-1:0] read_data_1;
  logic [DATA_WIDTH-1:0] read_data_2;
  logic                  mark_busy;
  logic [ADDR_WIDTH-1:0] mark_register;
  logic                  busy_1;
  logic                  busy_2;
  logic [ADDR_WIDTH:0]   busy_count;

  modport master (
    output reg_write, write_register, write_data,
    output read_register_1, read_register_2,
    output mark_busy, mark_register,
    input  read_data_1, read_data_2,
    input  busy_1, busy_2, busy_count
  );

  modport slave (
    input  reg_write, write_register, write_data,
    input  read_register_1, read_register_2,
    input  mark_busy, mark_register,
    output read_data_1, read_data_2,
    output busy_1, busy_2, busy_count
  );
endinterface

// File: rtl/register_file.sv
// Register file with busy scoreboard; r0 reads zero, never busy.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input logic             clock,
  input logic             reset,
  register_file_if.slave  bus
);
  localparam int IW = $clog2(NUM_REGS);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busy_nxt;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_nxt;
  logic                  wr_ok;
  logic                  mk_ok;

  function automatic logic valid_idx(
    input logic [ADDR_WIDTH-1:0] a
  );
    return (a != '0) && (32'(a) < NUM_REGS);
  endfunction

  assign wr_ok = bus.reg_write &&
                 valid_idx(bus.write_register);
  assign mk_ok = bus.mark_busy &&
                 valid_idx(bus.mark_register);

  // clear first so a same-edge mark (new producer) wins
  always_comb begin
    busy_nxt = busy;
    if (wr_ok)
      busy_nxt[bus.write_register[IW-1:0]] = 1'b0;
    if (mk_ok)
      busy_nxt[bus.mark_register[IW-1:0]] = 1'b1;
    count_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++)
      count_nxt = count_nxt +
                  (ADDR_WIDTH+1)'(busy_nxt[i]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
      busy  <= '0;
      count <= '0;
    end else begin
      if (wr_ok)
        regs[bus.write_register[IW-1:0]] <=
          bus.write_data;
      busy  <= busy_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    bus.read_data_1 = '0;
    bus.busy_1      = 1'b0;
    if (valid_idx(bus.read_register_1)) begin
      bus.read_data_1 =
        regs[bus.read_register_1[IW-1:0]];
      bus.busy_1 = busy[bus.read_register_1[IW-1:0]];
    end
`ifdef REGFILE_BYPASS_EN
    if (!reset && wr_ok &&
        bus.write_register == bus.read_register_1) begin
      bus.read_data_1 = bus.write_data;
      bus.busy_1      = 1'b0;
    end
`endif
  end

  always_comb begin
    bus.read_data_2 = '0;
    bus.busy_2      = 1'b0;
    if (valid_idx(bus.read_register_2)) begin
      bus.read_data_2 =
        regs[bus.read_register_2[IW-1:0]];
      bus.busy_2 = busy[bus.read_register_2[IW-1:0]];
    end
`ifdef REGFILE_BYPASS_EN
    if (!reset && wr_ok &&
        bus.write_register == bus.read_register_2) begin
      bus.read_data_2 = bus.write_data;
      bus.busy_2      = 1'b0;
    end
`endif
  end

  assign bus.busy_count = count;
endmodule

// File: tb/tb_register_file.sv
// Randomized bench for register_file against an array-based model.
// Honours REGFILE_BYPASS_EN in the expected read values.
module tb_register_file;
  logic clock;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;

  logic [31:0] mregs [32];
  bit          mbusy [32];

  register_file_if #(
    .DATA_WIDTH(32), .ADDR_WIDTH(5)
  ) bus ();

  register_file #(
    .DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(32)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  function automatic bit bypass_hit(input logic [4:0] idx);
`ifdef REGFILE_BYPASS_EN
    return !reset && bus.reg_write &&
           bus.write_register != 0 &&
           bus.write_register == idx;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] idx);
    if (idx == 0) return 32'h0;
    if (bypass_hit(idx)) return bus.write_data;
    return mregs[idx];
  endfunction

  function automatic logic exp_bz(input logic [4:0] idx);
    if (idx == 0 || bypass_hit(idx)) return 1'b0;
    return mbusy[idx];
  endfunction

  function automatic int exp_cnt();
    int s = 0;
    for (int i = 0; i < 32; i++) s += int'(mbusy[i]);
    return s;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      mregs[i] = '0;
      mbusy[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (bus.reg_write && bus.write_register != 0) begin
      mregs[bus.write_register] = bus.write_data;
      mbusy[bus.write_register] = 1'b0;
    end
    if (bus.mark_busy && bus.mark_register != 0)
      mbusy[bus.mark_register] = 1'b1;
  endtask

  task automatic check_all();
    chk("rd1", 64'(bus.read_data_1),
        64'(exp_rd(bus.read_register_1)));
    chk("rd2", 64'(bus.read_data_2),
        64'(exp_rd(bus.read_register_2)));
    chk("bz1", 64'(bus.busy_1),
        64'(exp_bz(bus.read_register_1)));
    chk("bz2", 64'(bus.busy_2),
        64'(exp_bz(bus.read_register_2)));
    chk("cnt", 64'(bus.busy_count), 64'(exp_cnt()));
  endtask

  task automatic drive(input logic we,
                       input logic [4:0] wa,
                       input logic [31:0] wd,
                       input logic mb,
                       input logic [4:0] ma,
                       input logic [4:0] r1,
                       input logic [4:0] r2);
    bus.reg_write       = we;
    bus.write_register  = wa;
    bus.write_data      = wd;
    bus.mark_busy       = mb;
    bus.mark_register   = ma;
    bus.read_register_1 = r1;
    bus.read_register_2 = r2;
  endtask

  task automatic step(input logic we,
                      input logic [4:0] wa,
                      input logic [31:0] wd,
                      input logic mb,
                      input logic [4:0] ma,
                      input logic [4:0] r1,
                      input logic [4:0] r2);
    drive(we, wa, wd, mb, ma, r1, r2);
    #2;
    check_all();
  endtask

  task automatic tick();
    @(posedge clock);
    if (!reset) model_edge();
    #1;
  endtask

  logic [31:0] byp_exp;

  initial begin
    reset = 1'b1;
    model_clear();
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      bus.read_register_1 = 5'(i);
      bus.read_register_2 = 5'(31 - i);
      #1;
      chk("rst_rd1", 64'(bus.read_data_1), 64'h0);
      chk("rst_rd2", 64'(bus.read_data_2), 64'h0);
      chk("rst_bz1", 64'(bus.busy_1), 64'h0);
      chk("rst_bz2", 64'(bus.busy_2), 64'h0);
    end
    chk("rst_cnt", 64'(bus.busy_count), 64'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0); tick();
    step(0, 0, 0, 0, 0, 5, 5);
    chk("r5_p1", 64'(bus.read_data_1), 64'hDEADBEEF);
    chk("r5_p2", 64'(bus.read_data_2), 64'hDEADBEEF);
    tick();
    step(1, 0, 32'h12345678, 0, 0, 0, 0); tick();
    step(0, 0, 0, 0, 0, 0, 5);
    chk("r0_zero", 64'(bus.read_data_1), 64'h0);
    tick();

    step(0, 0, 0, 1, 7, 0, 0); tick();
    step(0, 0, 0, 1, 9, 7, 0);
    chk("cnt_1", 64'(bus.busy_count), 64'd1);
    chk("bz_r7", 64'(bus.busy_1), 64'd1);
    tick();
    step(0, 0, 0, 0, 0, 7, 9);
    chk("cnt_2", 64'(bus.busy_count), 64'd2);
    tick();
    step(1, 7, 32'h55, 0, 0, 0, 0); tick();
    step(0, 0, 0, 0, 0, 7, 9);
    chk("cnt_wr7", 64'(bus.busy_count), 64'd1);
    chk("bz_r7_clr", 64'(bus.busy_1), 64'd0);
    chk("rd_r7", 64'(bus.read_data_1), 64'h55);
    chk("bz_r9", 64'(bus.busy_2), 64'd1);
    tick();

    step(1, 3, 32'hAA, 1, 3, 0, 0); tick();
    step(0, 0, 0, 0, 0, 3, 0);
    chk("setwin_bz", 64'(bus.busy_1), 64'd1);
    chk("setwin_rd", 64'(bus.read_data_1), 64'hAA);
    chk("setwin_cnt", 64'(bus.busy_count), 64'd2);
    tick();

`ifdef REGFILE_BYPASS_EN
    byp_exp = 32'hCAFE;
`else
    byp_exp = 32'h0;
`endif
    step(1, 10, 32'hCAFE, 1, 10, 10, 0);
    chk("byp_same", 64'(bus.read_data_1), 64'(byp_exp));
    tick();
    step(0, 0, 0, 0, 0, 10, 0);
    chk("byp_next", 64'(bus.read_data_1), 64'hCAFE);
    tick();

    step(1, 4, 32'h99, 1, 4, 0, 0); tick();
    step(0, 0, 0, 0, 0, 4, 0);
    chk("r4_pre", 64'(bus.read_data_1), 64'h99);
    chk("r4_bz_pre", 64'(bus.busy_1), 64'd1);
    #1;
    reset = 1'b1;
    model_clear();
    #1;
    chk("arst_rd", 64'(bus.read_data_1), 64'h0);
    chk("arst_bz", 64'(bus.busy_1), 64'h0);
    chk("arst_cnt", 64'(bus.busy_count), 64'h0);
    drive(1, 6, 32'h77, 1, 6, 6, 4);
    @(posedge clock);
    #1;
    reset = 1'b0;
    step(0, 0, 0, 0, 0, 6, 4);
    chk("rst_drop_wr", 64'(bus.read_data_1), 64'h0);
    chk("rst_drop_mk", 64'(bus.busy_1), 64'h0);
    tick();

    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)),
           5'($urandom_range(0, 15)),
           $urandom(),
           1'($urandom_range(0, 2) == 0),
           5'($urandom_range(0, 15)),
           5'($urandom_range(0, 31)),
           5'($urandom_range(0, 15)));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
